// File: rtl/axis_ram_trigger_writer.sv
// AXI-Stream to BRAM ring-buffer writer with trigger-stopped capture.
// Free-runs until a trigger, writes a programmable post-trigger tail, then freezes.
module axis_ram_trigger_writer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH  = 14
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,

  input  logic                        cfg_enable,
  input  logic [31:0]                 cfg_post_len,
  input  logic                        trig,

  output logic                        bram_porta_we,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  output logic [AXIS_TDATA_WIDTH-1:0] bram_porta_wrdata,

  output logic [BRAM_ADDR_WIDTH-1:0]  sts_wr_ptr,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_trig_addr,
  output logic [31:0]                 sts_wrap_cnt,
  output logic                        sts_done
);

  typedef enum logic [1:0] {IDLE, RUN, POST, DONE} state_t;

  state_t                      r_state;
  logic [BRAM_ADDR_WIDTH-1:0]  r_wr_ptr;
  logic [BRAM_ADDR_WIDTH-1:0]  r_trig_addr;
  logic [31:0]                 r_wrap_cnt;
  logic [31:0]                 r_post_cnt;
  logic                        r_done;
  logic                        r_we;
  logic [BRAM_ADDR_WIDTH-1:0]  r_addr;
  logic [AXIS_TDATA_WIDTH-1:0] r_wrdata;

  logic w_accept;
  logic w_write;
  logic w_ptr_last;

  // Never back-pressure: beats outside RUN/POST are simply dropped.
  assign s_axis_tready = 1'b1;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_write       = w_accept & ((r_state == RUN) | (r_state == POST));
  assign w_ptr_last    = &r_wr_ptr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_trig_addr <= '0;
      r_wrap_cnt  <= '0;
      r_post_cnt  <= '0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wrdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (!cfg_enable) begin
        r_state     <= IDLE;
        r_wr_ptr    <= '0;
        r_trig_addr <= '0;
        r_wrap_cnt  <= '0;
        r_post_cnt  <= '0;
        r_done      <= 1'b0;
      end else begin
        if (w_write) begin
          r_we     <= 1'b1;
          r_addr   <= r_wr_ptr;
          r_wrdata <= s_axis_tdata;
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_ptr_last && (r_wrap_cnt != 32'hFFFF_FFFF))
            r_wrap_cnt <= r_wrap_cnt + 32'd1;
        end
        case (r_state)
          IDLE: r_state <= RUN;
          RUN: begin
            // The beat accepted alongside the trigger is still pre-trigger data.
            if (trig) begin
              r_trig_addr <= r_wr_ptr;
              r_post_cnt  <= cfg_post_len;
              if (cfg_post_len == 32'd0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= POST;
              end
            end
          end
          POST: begin
            if (w_accept) begin
              r_post_cnt <= r_post_cnt - 32'd1;
              if (r_post_cnt == 32'd1) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end
          DONE:    r_state <= DONE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bram_porta_we     = r_we;
  assign bram_porta_addr   = r_addr;
  assign bram_porta_wrdata = r_wrdata;
  assign sts_wr_ptr        = r_wr_ptr;
  assign sts_trig_addr     = r_trig_addr;
  assign sts_wrap_cnt      = r_wrap_cnt;
  assign sts_done          = r_done;

endmodule

// File: doc/axis_ram_trigger_writer.md
Name: axis_ram_trigger_writer

Overview:
- Downstream consumer of the stream-breaker stage. Writes accepted AXI-Stream beats into a BRAM ring buffer through port A.
- Runs free until a trigger arrives, then writes a programmable number of post-trigger beats and freezes. Software can then read the pre-trigger and post-trigger history.
- Reports write pointer, trigger address, wrap count and done status.

Parameters:
- AXIS_TDATA_WIDTH, 32, stream data width; also the BRAM word width.
- BRAM_ADDR_WIDTH, 14, ring depth is 2^BRAM_ADDR_WIDTH words.

Ports:
- aclk  in  1  system clock; all logic on its rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tready  out  1  slave ready.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  slave data.
- s_axis_tvalid  in  1  slave valid.
- cfg_enable  in  1  level; low forces IDLE and clears pointers.
- cfg_post_len  in  32  number of beats written after the trigger; sampled on trigger.
- trig  in  1  single-cycle trigger pulse, synchronous to aclk.
- bram_porta_we  out  1  BRAM write enable.
- bram_porta_addr  out  BRAM_ADDR_WIDTH  BRAM write address.
- bram_porta_wrdata  out  AXIS_TDATA_WIDTH  BRAM write data.
- sts_wr_ptr  out  BRAM_ADDR_WIDTH  next address to be written.
- sts_trig_addr  out  BRAM_ADDR_WIDTH  address of the beat accepted in the trigger cycle, or of the next write if no beat was accepted then.
- sts_wrap_cnt  out  32  number of pointer wraps, saturating.
- sts_done  out  1  capture complete.

Behaviour:
- Reset (aresetn low, asynchronous):
  - State = IDLE.
  - All pointers, counters and status outputs = 0.
  - bram_porta_we = 0; bram_porta_addr and bram_porta_wrdata = 0.
- s_axis_tready = 1 in every state. The block never back-pressures: beats are either written or discarded.
- Accept = s_axis_tvalid & s_axis_tready.
- Write pipeline, latency 1:
  - A beat accepted in cycle n while in RUN or POST produces bram_porta_we = 1 in cycle n+1.
  - In that cycle, bram_porta_addr = wr_ptr value at cycle n and bram_porta_wrdata = tdata at cycle n.
  - bram_porta_we = 0 otherwise.
- wr_ptr increments by 1 per written beat and wraps from 2^BRAM_ADDR_WIDTH-1 to 0. On each wrap, sts_wrap_cnt increments, saturating at 0xFFFFFFFF.
- State IDLE:
  - Beats discarded; wr_ptr, wrap count, post counter and sts_done held at 0.
  - cfg_enable = 1 -> RUN on the next cycle.
- State RUN:
  - Every accepted beat is written.
  - trig = 1:
    - sts_trig_addr latches the current wr_ptr (the address the same-cycle beat takes, if any).
    - post_cnt loads cfg_post_len.
    - Next state is POST, or DONE if cfg_post_len == 0.
  - The beat accepted in the trigger cycle is written and counts as pre-trigger.
- State POST:
  - Every accepted beat is written and decrements post_cnt.
  - When a beat is accepted with post_cnt == 1 -> DONE. That beat is still written.
  - trig is ignored.
  - cfg_post_len >= depth is legal; pre-trigger data is then overwritten.
- State DONE:
  - Beats discarded; sts_done = 1; pointers and status frozen.
  - trig is ignored.
- cfg_enable = 0 in any state:
  - Next state IDLE.
  - wr_ptr, sts_wrap_cnt, sts_trig_addr, post_cnt and sts_done cleared at that edge.
  - An already-registered write still completes in the following cycle.
  - A beat accepted in that same cycle is discarded.
- Re-arm: cfg_enable low for at least 1 cycle, then high.
- Reset mid-capture: all state is lost immediately, with no write issued after reset asserts.
- Status outputs are registered and update in the cycle after the causing edge.

Test Plan:
- BRAM_ADDR_WIDTH=4, reset, cfg_enable=1, 5 consecutive beats 0xA0..0xA4 -> we pulses at addr 0..4 with data 0xA0..0xA4, each one cycle after acceptance; sts_wr_ptr=5; sts_wrap_cnt=0.
- Stream 35 beats -> addresses wrap twice; last write at addr 2; sts_wr_ptr=3; sts_wrap_cnt=2.
- cfg_post_len=3, trig coincident with beat written at addr 6, then 5 more beats -> sts_trig_addr=6; writes at 7, 8, 9 only; sts_done=1; sts_wr_ptr=10; later beats produce no we.
- cfg_post_len=0, trig with no valid beat while wr_ptr=4 -> sts_trig_addr=4; DONE next cycle; no further writes.
- Drop cfg_enable in POST for 1 cycle, then raise -> sts_done=0, sts_wr_ptr=0, sts_wrap_cnt=0; next beat written at addr 0.
- Pulse aresetn low asynchronously mid-POST -> all outputs 0 before the next clock edge; bram_porta_we=0.
